dmem_responder: RTL and testbench

//   Data-memory responder for the pipelined core's load/store port.

---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// Takes one word request at a time over valid/ready and answers LATENCY
// edges after acceptance with a single-cycle rsp_valid pulse. busy tells
// the hazard unit a request is outstanding so it can freeze the pipeline.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    // Configuration sanity: the wait counter is 4 bits wide, and the
    // word index must be a clean slice of the byte address.
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
        if (DEPTH < 4 || (1 << AW) != DEPTH || AW > 29) begin : g_bad_depth
            $error("dmem_responder: DEPTH must be a power of 2, >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          to_resp;
    logic          addr_err;
    logic [AW-1:0] idx;

    assign accept   = req_valid && req_ready;
    assign to_resp  = (state == WAIT) && (cnt == 4'd0);
    // Misaligned, or any address bit above the array span is set.
    assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:AW+2] != '0);
    assign idx      = lat_addr[AW+1:2];

    // State register; reset drops any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP when the
    // counter expires, RESP always returns to IDLE (no backpressure).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational handshake outputs derived directly from state.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // Request capture and wait countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            cnt       <= CNT_INIT;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Registered response; rdata is zero for stores and errors and
    // otherwise holds its last value between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= to_resp;
            rsp_err   <= to_resp && addr_err;
            if (to_resp) begin
                rsp_rdata <= (lat_we || addr_err) ? 32'd0 : mem[idx];
            end
        end
    end

    // Storage array, not reset; stores commit only on a clean WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (to_resp && lat_we && !addr_err) begin
            mem[idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance A (LATENCY=2) and
// instance B (LATENCY=1), directed vectors with hand-computed results.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .busy(a_busy)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per response pulse and compare.
    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rdata", a_rsp_rdata, e.rdata);
                chk("a_err", {31'd0, a_rsp_err}, {31'd0, e.err});
                chk("a_rsp_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (b_rsp_valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rdata", b_rsp_rdata, e.rdata);
                chk("b_err", {31'd0, b_rsp_err}, {31'd0, e.err});
                chk("b_rsp_cycle", cyc, e.due);
            end
        end
    end

    // Issue one request and optionally push its expected response.
    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic issue(input bit on_b, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit push);
        int   n = 0;
        exp_t e;
        if (on_b) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
            while (!b_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
            while (!a_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.due   = cyc + 1 + (on_b ? 1 : 2);
        if (push) begin
            if (on_b) qb.push_back(e); else qa.push_back(e);
        end
        @(posedge clk); #1;
        if (on_b) b_req_valid = 1'b0; else a_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int extra);
        int n = 0;
        while ((a_busy || b_busy) && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
        repeat (extra) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int prev;
        // Reset state
        #12;
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: store then load same word
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        wait_idle(1);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_idle(1);

        // 2: back-to-back loads @0 and @4 with req_valid held high
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h0;
        chk("b2b_ready_k", {31'd0, a_req_ready}, 32'd1);
        k = cyc + 1;
        qa.push_back('{rdata: 32'h0, err: 1'b0, due: k + 2});
        @(posedge clk); #1;
        a_req_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_ready_low", {31'd0, a_req_ready}, 32'd0);
            chk("b2b_busy_high", {31'd0, a_busy}, 32'd1);
            @(posedge clk); #1;
        end
        chk("b2b_ready_k4", {31'd0, a_req_ready}, 32'd1);
        chk("b2b_second_accept", cyc + 1, k + 4);
        qa.push_back('{rdata: 32'h0, err: 1'b0, due: cyc + 3});
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        wait_idle(1);

        // 3: misaligned store is rejected, memory untouched
        issue(1'b0, 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1, 1'b1);
        wait_idle(1);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_idle(1);

        // 4: range boundary
        issue(1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1);
        wait_idle(1);
        issue(1'b0, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_idle(1);

        // 5: reset during WAIT drops the store
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_idle(1);
        issue(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_busy", {31'd0, a_busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, a_busy}, 32'd0);
        chk("midrst_ready", {31'd0, a_req_ready}, 32'd1);
        chk("midrst_rdata", a_rsp_rdata, 32'd0);
        chk("midrst_valid", {31'd0, a_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        issue(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_idle(1);

        // 6: LATENCY=1 instance, loads streamed with req_valid held high
        issue(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        wait_idle(1);
        b_req_valid = 1'b1; b_req_we = 1'b0;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            b_req_addr = 32'(i * 4);
            while (!b_req_ready && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) chk("l1_accept_timeout", 32'd1, 32'd0);
            k = cyc + 1;
            if (i > 0) chk("l1_accept_spacing", k - prev, 32'd3);
            prev = k;
            qb.push_back('{rdata: (i == 2) ? 32'hA5A5A5A5 : 32'h0, err: 1'b0, due: k + 1});
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;
        wait_idle(3);

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
